// File: rtl/spi_data_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_data_pkg
// Purpose  : Shared command/header constants and responder state encoding
//            for the video/audio SPI data request protocol. The data request
//            FSM imports the same command constants.
// Contents : AUDIO_CMD, VIDEO_CMD, AUDIO_HDR, VIDEO_HDR, resp_state_t,
//            max_len() helper for counter sizing.
// Revision : 1.0 - initial release
// ============================================================================
package spi_data_pkg;

  localparam logic [7:0] AUDIO_CMD = 8'hAA;
  localparam logic [7:0] VIDEO_CMD = 8'hFA;
  localparam logic [7:0] AUDIO_HDR = 8'hA5;
  localparam logic [7:0] VIDEO_HDR = 8'hF5;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CMD     = 3'd1,
    HDR     = 3'd2,
    PAYLOAD = 3'd3,
    TAIL    = 3'd4
  } resp_state_t;

  function automatic int max_len(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_sync_edge.sv
`default_nettype none
// ============================================================================
// Module   : spi_sync_edge
// Purpose  : Multi-stage synchronizer for the asynchronous SPI pins plus
//            edge detection on the synchronized levels.
// Ports    : CLK_40, reset          - system clock, sync active-high reset
//            sclk, mosi, ss_n       - raw SPI pins
//            mosi_s, ss_n_s         - synchronized levels
//            sclk_rise, sclk_fall   - SCLK edge pulses, only while ss_n_s low
//            ss_fall, ss_rise       - chip-select edge pulses
// Revision : 1.0 - initial release
// ============================================================================
module spi_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic CLK_40,
  input  logic reset,
  input  logic sclk,
  input  logic mosi,
  input  logic ss_n,
  output logic mosi_s,
  output logic ss_n_s,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic ss_fall,
  output logic ss_rise
);

  logic [SYNC_STAGES-1:0] r_sclk_pipe;
  logic [SYNC_STAGES-1:0] r_mosi_pipe;
  logic [SYNC_STAGES-1:0] r_ss_pipe;
  logic                   r_sclk_prev;
  logic                   r_ss_prev;
  logic                   w_sclk;
  logic                   w_ss;

  // The chip-select chain resets to 0 ("already selected"): a select held
  // low through reset then produces no falling edge, so the responder waits
  // for a genuine deselect/reselect before starting a transaction.
  always_ff @(posedge CLK_40) begin
    if (reset) begin
      r_sclk_pipe <= '0;
      r_mosi_pipe <= '0;
      r_ss_pipe   <= '0;
      r_sclk_prev <= 1'b0;
      r_ss_prev   <= 1'b0;
    end else begin
      r_sclk_pipe <= {r_sclk_pipe[SYNC_STAGES-2:0], sclk};
      r_mosi_pipe <= {r_mosi_pipe[SYNC_STAGES-2:0], mosi};
      r_ss_pipe   <= {r_ss_pipe[SYNC_STAGES-2:0], ss_n};
      r_sclk_prev <= r_sclk_pipe[SYNC_STAGES-1];
      r_ss_prev   <= r_ss_pipe[SYNC_STAGES-1];
    end
  end

  assign w_sclk    = r_sclk_pipe[SYNC_STAGES-1];
  assign w_ss      = r_ss_pipe[SYNC_STAGES-1];
  assign mosi_s    = r_mosi_pipe[SYNC_STAGES-1];
  assign ss_n_s    = w_ss;
  assign sclk_rise =  w_sclk & ~r_sclk_prev & ~w_ss;
  assign sclk_fall = ~w_sclk &  r_sclk_prev & ~w_ss;
  assign ss_fall   = ~w_ss &  r_ss_prev;
  assign ss_rise   =  w_ss & ~r_ss_prev;

endmodule
`default_nettype wire

// File: rtl/spi_data_responder.sv
`default_nettype none
// ============================================================================
// Module   : spi_data_responder
// Purpose  : SPI mode-0 slave serving video/audio data requests. Decodes the
//            command byte, answers with a header byte and a fixed-length
//            payload pulled from valid/ready byte sources.
// Ports    : CLK_40, reset                 - clock, sync active-high reset
//            SCLK, MOSI, SS_n, MISO        - SPI pins (inputs asynchronous)
//            vid_data/valid/ready          - video byte source
//            aud_data/valid/ready          - audio byte source
//            busy, xfer_done, underrun, cmd_err - status
// Options  : `define SPI_RESP_CHECKSUM_EN appends an XOR checksum byte after
//            the payload.
// Revision : 1.0 - initial release
// ============================================================================
module spi_data_responder
  import spi_data_pkg::*;
#(
  parameter int         VIDEO_LEN   = 9600,
  parameter int         AUDIO_LEN   = 1024,
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] FILL_BYTE   = 8'hFF
) (
  input  logic       CLK_40,
  input  logic       reset,
  input  logic       SCLK,
  input  logic       MOSI,
  input  logic       SS_n,
  output logic       MISO,
  input  logic [7:0] vid_data,
  input  logic       vid_valid,
  output logic       vid_ready,
  input  logic [7:0] aud_data,
  input  logic       aud_valid,
  output logic       aud_ready,
  output logic       busy,
  output logic       xfer_done,
  output logic       underrun,
  output logic       cmd_err
);

  localparam int CNT_W = $clog2(max_len(VIDEO_LEN, AUDIO_LEN) + 1);

  logic             w_mosi_s;
  logic             w_ss_n_s;
  logic             w_sclk_rise;
  logic             w_sclk_fall;
  logic             w_ss_fall;
  logic             w_ss_rise;

  resp_state_t      r_state;
  logic [2:0]       r_bit_cnt;
  logic [7:0]       r_rx_sr;
  logic [7:0]       r_tx_sr;
  logic [7:0]       r_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_src_aud;
  logic             r_vid_ready;
  logic             r_aud_ready;
  logic             r_xfer_done;
  logic             r_underrun;
  logic             r_cmd_err;
`ifdef SPI_RESP_CHECKSUM_EN
  logic [7:0]       r_csum;
`endif

  logic [7:0]       w_rx_byte;
  logic             w_src_valid;
  logic [7:0]       w_pop_byte;

  spi_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .CLK_40    (CLK_40),
    .reset     (reset),
    .sclk      (SCLK),
    .mosi      (MOSI),
    .ss_n      (SS_n),
    .mosi_s    (w_mosi_s),
    .ss_n_s    (w_ss_n_s),
    .sclk_rise (w_sclk_rise),
    .sclk_fall (w_sclk_fall),
    .ss_fall   (w_ss_fall),
    .ss_rise   (w_ss_rise)
  );

  assign w_rx_byte   = {r_rx_sr[6:0], w_mosi_s};
  assign w_src_valid = r_src_aud ? aud_valid : vid_valid;
  // Byte fetched (or substituted on underrun) at a payload byte boundary.
  assign w_pop_byte  = w_src_valid ? (r_src_aud ? aud_data : vid_data) : FILL_BYTE;

  always_ff @(posedge CLK_40) begin
    if (reset) begin
      r_state     <= IDLE;
      r_bit_cnt   <= 3'd0;
      r_rx_sr     <= 8'h00;
      r_tx_sr     <= FILL_BYTE;
      r_next      <= FILL_BYTE;
      r_cnt       <= '0;
      r_src_aud   <= 1'b0;
      r_vid_ready <= 1'b0;
      r_aud_ready <= 1'b0;
      r_xfer_done <= 1'b0;
      r_underrun  <= 1'b0;
      r_cmd_err   <= 1'b0;
`ifdef SPI_RESP_CHECKSUM_EN
      r_csum      <= 8'h00;
`endif
    end else begin
      r_vid_ready <= 1'b0;
      r_aud_ready <= 1'b0;
      r_xfer_done <= 1'b0;
      r_cmd_err   <= 1'b0;

      // Deselect has priority over everything, including a coincident
      // byte boundary, so a truncated transfer never pops or completes.
      if (w_ss_rise) begin
        r_state <= IDLE;
      end else if (w_ss_fall) begin
        r_tx_sr   <= FILL_BYTE;
        r_bit_cnt <= 3'd0;
        r_state   <= CMD;
      end else if (r_state != IDLE) begin
        if (w_sclk_rise) begin
          r_rx_sr   <= w_rx_byte;
          r_bit_cnt <= r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) begin
            case (r_state)
              CMD: begin
                if (w_rx_byte == VIDEO_CMD) begin
                  r_next     <= VIDEO_HDR;
                  r_src_aud  <= 1'b0;
                  r_cnt      <= CNT_W'(VIDEO_LEN);
                  r_state    <= HDR;
                  r_underrun <= 1'b0;
`ifdef SPI_RESP_CHECKSUM_EN
                  r_csum     <= 8'h00;
`endif
                end else if (w_rx_byte == AUDIO_CMD) begin
                  r_next     <= AUDIO_HDR;
                  r_src_aud  <= 1'b1;
                  r_cnt      <= CNT_W'(AUDIO_LEN);
                  r_state    <= HDR;
                  r_underrun <= 1'b0;
`ifdef SPI_RESP_CHECKSUM_EN
                  r_csum     <= 8'h00;
`endif
                end else begin
                  r_cmd_err <= 1'b1;
                  r_next    <= FILL_BYTE;
                  r_state   <= TAIL;
                end
              end
              HDR, PAYLOAD: begin
                if (r_cnt != '0) begin
                  r_next      <= w_pop_byte;
                  r_cnt       <= r_cnt - CNT_W'(1);
                  r_state     <= PAYLOAD;
                  r_vid_ready <= w_src_valid & ~r_src_aud;
                  r_aud_ready <= w_src_valid &  r_src_aud;
                  if (!w_src_valid) begin
                    r_underrun <= 1'b1;
                  end
`ifdef SPI_RESP_CHECKSUM_EN
                  r_csum      <= r_csum ^ w_pop_byte;
`endif
                end else begin
`ifdef SPI_RESP_CHECKSUM_EN
                  r_next      <= r_csum;
`else
                  r_next      <= FILL_BYTE;
`endif
                  r_xfer_done <= 1'b1;
                  r_state     <= TAIL;
                end
              end
              default: begin
                r_next <= FILL_BYTE;
              end
            endcase
          end
        end

        // Mode 0: the next bit is presented after the master's sampling edge.
        if (w_sclk_fall) begin
          if (r_bit_cnt == 3'd0) begin
            r_tx_sr <= r_next;
          end else begin
            r_tx_sr <= {r_tx_sr[6:0], 1'b0};
          end
        end
      end
    end
  end

  assign MISO      = (r_state != IDLE && !w_ss_n_s) ? r_tx_sr[7] : 1'b1;
  assign busy      = (r_state != IDLE);
  assign vid_ready = r_vid_ready;
  assign aud_ready = r_aud_ready;
  assign xfer_done = r_xfer_done;
  assign underrun  = r_underrun;
  assign cmd_err   = r_cmd_err;

endmodule
`default_nettype wire
